// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - blocking I-cache miss handler: one burst read per miss, assembled into a refill line
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   miss_req_*                        frontend miss request (paddr any offset, victim way)
//   mem_req_*                         line-aligned burst read request (beats = BEATS-1)
//   mem_resp_*                        read beats, beat 0 is the lowest address
//   refill_*                          assembled line back to the cache
//   busy_o                            controller not idle
//   proto_err_o                       one-cycle pulse when a burst length disagrees with BEATS
//   miss_count_o                      accepted misses, wrapping
module icache_refill_ctrl #(
    parameter int PLEN       = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BUS_WIDTH  = 64,
    parameter int WAY_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  miss_req_valid_i,
    output logic                  miss_req_ready_o,
    input  logic [PLEN-1:0]       miss_req_paddr_i,
    input  logic [WAY_WIDTH-1:0]  miss_req_victim_way_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PLEN-1:0]       mem_req_addr_o,
    output logic [7:0]            mem_req_beats_o,
    input  logic                  mem_resp_valid_i,
    output logic                  mem_resp_ready_o,
    input  logic [BUS_WIDTH-1:0]  mem_resp_data_i,
    input  logic                  mem_resp_last_i,
    output logic                  refill_valid_o,
    input  logic                  refill_ready_i,
    output logic [PLEN-1:0]       refill_paddr_o,
    output logic [WAY_WIDTH-1:0]  refill_way_o,
    output logic [LINE_WIDTH-1:0] refill_data_o,
    output logic                  busy_o,
    output logic                  proto_err_o,
    output logic [31:0]           miss_count_o
);

    localparam int BEATS       = LINE_WIDTH / BUS_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    // One extra bit so the counter cannot wrap inside a burst.
    localparam int CNT_W       = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        REFILL
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           count_q, count_d;
    logic                  err_q, err_d;
    logic [PLEN-1:0]       addr_q, addr_d;
    logic [WAY_WIDTH-1:0]  way_q, way_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  final_beat;

    assign final_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        count_d          = count_q;
        err_d            = 1'b0;
        addr_d           = addr_q;
        way_d            = way_q;
        line_d           = line_q;
        miss_req_ready_o = 1'b0;
        mem_req_valid_o  = 1'b0;
        mem_resp_ready_o = 1'b0;
        refill_valid_o   = 1'b0;
        case (state_q)
            IDLE: begin
                miss_req_ready_o = 1'b1;
                // Stray beats of an abandoned burst are accepted and dropped.
                mem_resp_ready_o = 1'b1;
                if (miss_req_valid_i) begin
                    addr_d  = {miss_req_paddr_i[PLEN-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    way_d   = miss_req_victim_way_i;
                    count_d = count_q + 32'd1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_d[k*BUS_WIDTH +: BUS_WIDTH] = mem_resp_data_i;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    // An early last still closes the line; missing words stay stale.
                    if (final_beat || mem_resp_last_i) begin
                        state_d = REFILL;
                    end
                    err_d = final_beat ^ mem_resp_last_i;
                end
            end
            REFILL: begin
                refill_valid_o = 1'b1;
                if (refill_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        way_q  <= way_d;
        line_q <= line_d;
    end

    assign mem_req_addr_o  = addr_q;
    assign mem_req_beats_o = 8'(BEATS - 1);
    assign refill_paddr_o  = addr_q;
    assign refill_way_o    = way_q;
    assign refill_data_o   = line_q;
    assign busy_o          = (state_q != IDLE);
    assign proto_err_o     = err_q;
    assign miss_count_o    = count_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         miss_req_valid_i;
    logic         miss_req_ready_o;
    logic [31:0]  miss_req_paddr_i;
    logic [1:0]   miss_req_victim_way_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic [7:0]   mem_req_beats_o;
    logic         mem_resp_valid_i;
    logic         mem_resp_ready_o;
    logic [63:0]  mem_resp_data_i;
    logic         mem_resp_last_i;
    logic         refill_valid_o;
    logic         refill_ready_i;
    logic [31:0]  refill_paddr_o;
    logic [1:0]   refill_way_o;
    logic [255:0] refill_data_o;
    logic         busy_o;
    logic         proto_err_o;
    logic [31:0]  miss_count_o;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .miss_req_valid_i      (miss_req_valid_i),
        .miss_req_ready_o      (miss_req_ready_o),
        .miss_req_paddr_i      (miss_req_paddr_i),
        .miss_req_victim_way_i (miss_req_victim_way_i),
        .mem_req_valid_o       (mem_req_valid_o),
        .mem_req_ready_i       (mem_req_ready_i),
        .mem_req_addr_o        (mem_req_addr_o),
        .mem_req_beats_o       (mem_req_beats_o),
        .mem_resp_valid_i      (mem_resp_valid_i),
        .mem_resp_ready_o      (mem_resp_ready_o),
        .mem_resp_data_i       (mem_resp_data_i),
        .mem_resp_last_i       (mem_resp_last_i),
        .refill_valid_o        (refill_valid_o),
        .refill_ready_i        (refill_ready_i),
        .refill_paddr_o        (refill_paddr_o),
        .refill_way_o          (refill_way_o),
        .refill_data_o         (refill_data_o),
        .busy_o                (busy_o),
        .proto_err_o           (proto_err_o),
        .miss_count_o          (miss_count_o)
    );

    typedef struct {
        logic [31:0] paddr;
        logic [1:0]  way;
        int          nb;            // beats sent; <4 means last arrives early
        bit          last_on_final; // last flag on beat 3 when nb==4
        int          req_wait;
        int          refill_wait;
        bit          hold_next;     // keep next miss asserted while busy
        logic [31:0] exp_addr;
        bit          exp_err;
    } vec_t;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [255:0] model_line = '0;
    logic [31:0]  model_count = '0;
    vec_t         tbl[7];
    vec_t         rv;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_miss(input vec_t v, input bit fixed, input logic [31:0] nxt_paddr,
                           input logic [1:0] nxt_way, input int gap_max);
        logic [63:0]  beats[4];
        logic [255:0] exp_line;
        int           t;
        for (int k = 0; k < 4; k++) begin
            beats[k] = fixed ? {16{4'(k + 1)}} : {$urandom, $urandom};
        end
        exp_line = model_line;
        for (int k = 0; k < v.nb; k++) exp_line[k*64 +: 64] = beats[k];
        t = 0;
        while (!miss_req_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("miss_ready_wait", 256'(miss_req_ready_o), 256'(1));
        if (!miss_req_ready_o) return;
        miss_req_valid_i      = 1'b1;
        miss_req_paddr_i      = v.paddr;
        miss_req_victim_way_i = v.way;
        @(negedge clk);
        model_count = model_count + 32'd1;
        if (v.hold_next) begin
            miss_req_paddr_i      = nxt_paddr;
            miss_req_victim_way_i = nxt_way;
        end else begin
            miss_req_valid_i = 1'b0;
        end
        check("busy_after_accept", 256'(busy_o), 256'(1));
        check("miss_count", 256'(miss_count_o), 256'(model_count));
        repeat (v.req_wait) begin
            check("req_valid_held", 256'(mem_req_valid_o), 256'(1));
            check("req_addr_held", 256'(mem_req_addr_o), 256'(v.exp_addr));
            check("miss_ready_busy", 256'(miss_req_ready_o), 256'(0));
            @(negedge clk);
        end
        check("req_valid", 256'(mem_req_valid_o), 256'(1));
        check("req_addr", 256'(mem_req_addr_o), 256'(v.exp_addr));
        check("req_beats", 256'(mem_req_beats_o), 256'(3));
        check("resp_ready_in_req", 256'(mem_resp_ready_o), 256'(0));
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check("req_valid_drop", 256'(mem_req_valid_o), 256'(0));
        for (int k = 0; k < v.nb; k++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            check("resp_ready", 256'(mem_resp_ready_o), 256'(1));
            check("miss_ready_recv", 256'(miss_req_ready_o), 256'(0));
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = beats[k];
            mem_resp_last_i  = (k == v.nb - 1) ? ((v.nb < 4) ? 1'b1 : v.last_on_final) : 1'b0;
            @(negedge clk);
            mem_resp_valid_i = 1'b0;
            mem_resp_last_i  = 1'b0;
            if (k < v.nb - 1) check("refill_early", 256'(refill_valid_o), 256'(0));
        end
        model_line = exp_line;
        check("refill_valid_rise", 256'(refill_valid_o), 256'(1));
        check("proto_err", 256'(proto_err_o), 256'(v.exp_err));
        check("resp_ready_refill", 256'(mem_resp_ready_o), 256'(0));
        repeat (v.refill_wait) begin
            @(negedge clk);
            check("refill_valid_held", 256'(refill_valid_o), 256'(1));
            check("refill_data_held", refill_data_o, exp_line);
            check("proto_err_pulse", 256'(proto_err_o), 256'(0));
        end
        check("refill_data", refill_data_o, exp_line);
        check("refill_paddr", 256'(refill_paddr_o), 256'(v.exp_addr));
        check("refill_way", 256'(refill_way_o), 256'(v.way));
        check("miss_ready_refill", 256'(miss_req_ready_o), 256'(0));
        refill_ready_i = 1'b1;
        @(negedge clk);
        refill_ready_i = 1'b0;
        check("refill_valid_drop", 256'(refill_valid_o), 256'(0));
        check("proto_err_after", 256'(proto_err_o), 256'(0));
        check("miss_ready_after", 256'(miss_req_ready_o), 256'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h8000_0014, 2'd2, 4, 1'b1, 0, 0, 1'b0, 32'h8000_0000, 1'b0};
        tbl[1] = '{32'h1234_5678, 2'd1, 4, 1'b1, 5, 3, 1'b0, 32'h1234_5660, 1'b0};
        tbl[2] = '{32'h8000_0100, 2'd3, 4, 1'b1, 0, 1, 1'b1, 32'h8000_0100, 1'b0};
        tbl[3] = '{32'h8000_0040, 2'd0, 4, 1'b1, 0, 0, 1'b0, 32'h8000_0040, 1'b0};
        tbl[4] = '{32'hA000_003F, 2'd1, 2, 1'b1, 0, 0, 1'b0, 32'hA000_0020, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 2'd2, 4, 1'b0, 1, 0, 1'b0, 32'hFFFF_FFE0, 1'b1};
        tbl[6] = '{32'h0000_0007, 2'd0, 1, 1'b1, 0, 2, 1'b0, 32'h0000_0000, 1'b1};

        rst_i = 1'b1;
        miss_req_valid_i = 1'b0;
        miss_req_paddr_i = '0;
        miss_req_victim_way_i = '0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i = '0;
        mem_resp_last_i = 1'b0;
        refill_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check("rst_busy", 256'(busy_o), 256'(0));
        check("rst_req_valid", 256'(mem_req_valid_o), 256'(0));
        check("rst_refill_valid", 256'(refill_valid_o), 256'(0));
        check("rst_proto_err", 256'(proto_err_o), 256'(0));
        check("rst_miss_count", 256'(miss_count_o), 256'(0));
        check("rst_miss_ready", 256'(miss_req_ready_o), 256'(1));
        check("rst_resp_ready", 256'(mem_resp_ready_o), 256'(1));

        for (int i = 0; i < 7; i++) begin
            do_miss(tbl[i], i == 0, (i < 6) ? tbl[i+1].paddr : 32'h0,
                    (i < 6) ? tbl[i+1].way : 2'd0, (i == 0) ? 0 : 2);
            if (i == 0) begin
                check("basic_word0", 256'(refill_data_o[63:0]), 256'(64'h1111_1111_1111_1111));
                check("basic_word3", 256'(refill_data_o[255:192]), 256'(64'h4444_4444_4444_4444));
                check("basic_count", 256'(miss_count_o), 256'(1));
            end
            if (i == 3) check("busy_miss_count", 256'(miss_count_o), 256'(4));
        end

        // Reset in the middle of a burst, then stray beats in IDLE.
        miss_req_valid_i = 1'b1;
        miss_req_paddr_i = 32'h8000_0200;
        miss_req_victim_way_i = 2'd1;
        @(negedge clk);
        miss_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = {$urandom, $urandom};
            model_line[k*64 +: 64] = mem_resp_data_i;
            @(negedge clk);
        end
        mem_resp_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        model_count = '0;
        check("midrst_busy", 256'(busy_o), 256'(0));
        check("midrst_count", 256'(miss_count_o), 256'(0));
        for (int k = 0; k < 2; k++) begin
            check("stray_resp_ready", 256'(mem_resp_ready_o), 256'(1));
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = {$urandom, $urandom};
            mem_resp_last_i  = (k == 1);
            @(negedge clk);
            check("stray_no_refill", 256'(refill_valid_o), 256'(0));
        end
        mem_resp_valid_i = 1'b0;
        mem_resp_last_i  = 1'b0;
        @(negedge clk);
        check("stray_idle", 256'(busy_o), 256'(0));
        check("stray_no_err", 256'(proto_err_o), 256'(0));
        do_miss(tbl[3], 1'b0, 32'h0, 2'd0, 1);

        // Randomized transactions against the line/count model.
        for (int i = 0; i < 20; i++) begin
            rv.paddr         = $urandom;
            rv.way           = 2'($urandom_range(3, 0));
            rv.nb            = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 4;
            rv.last_on_final = (rv.nb < 4) ? 1'b1 : ($urandom_range(4, 0) != 0);
            rv.req_wait      = $urandom_range(3, 0);
            rv.refill_wait   = $urandom_range(3, 0);
            rv.hold_next     = 1'b0;
            rv.exp_addr      = rv.paddr & ~32'h1F;
            rv.exp_err       = (rv.nb != 4) || !rv.last_on_final;
            do_miss(rv, 1'b0, 32'h0, 2'd0, 2);
        end

        // Miss counter wrap.
        force dut.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.count_q;
        model_count = 32'hFFFF_FFFF;
        @(negedge clk);
        check("wrap_preset", 256'(miss_count_o), 256'(32'hFFFF_FFFF));
        do_miss(tbl[1], 1'b0, 32'h0, 2'd0, 1);
        check("wrap_zero", 256'(miss_count_o), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
